// File: rtl/uxa_ps2_deserializer.sv
// rtl/uxa_ps2_deserializer.sv - PS/2 receive deserializer: synchronize, glitch-filter clock, shift 11-bit frame.
// Optional parity error output enabled by macro UXA_PS2_PARITY_CHECK_EN.
module uxa_ps2_deserializer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       sys_clk_i,
    input  logic       reset_i,
    input  logic       ps2_d_i,
    input  logic       ps2_c_i,
    output logic [7:0] d_o,
`ifdef UXA_PS2_PARITY_CHECK_EN
    output logic       parity_err_o,
`else
`endif
    output logic       frame_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [SYNC_STAGES-1:0] c_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic                   c_s;
    logic                   d_s;
    logic [CNT_W-1:0]       filt_cnt;
    logic                   c_filt;
    logic                   c_prev;
    logic                   fall;
    logic [10:0]            sr;

    assign c_s = c_sync[SYNC_STAGES-1];
    assign d_s = d_sync[SYNC_STAGES-1];

    // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            c_sync <= '1;
            d_sync <= '1;
        end else begin
            c_sync <= {c_sync[SYNC_STAGES-2:0], ps2_c_i};
            d_sync <= {d_sync[SYNC_STAGES-2:0], ps2_d_i};
        end
    end

    // filt_cnt counts consecutive samples disagreeing with c_filt; it clears on
    // any agreeing sample and when the filtered clock flips, so it never wraps.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            filt_cnt <= '0;
            c_filt   <= 1'b1;
        end else if (c_s == c_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
            filt_cnt <= '0;
            c_filt   <= c_s;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            c_prev <= 1'b1;
        end else begin
            c_prev <= c_filt;
        end
    end

    assign fall = c_prev & ~c_filt;

    // New bit enters at the MSB so the start bit ends up in sr[0] after 11 falls.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            sr <= 11'h7FF;
        end else if (fall) begin
            sr <= {d_s, sr[10:1]};
        end
    end

    assign d_o     = sr[8:1];
    assign frame_o = ~sr[0] & sr[10];

`ifdef UXA_PS2_PARITY_CHECK_EN
    assign parity_err_o = frame_o & ~(^sr[9:1]);
`endif

endmodule

// File: tb/tb_uxa_ps2_deserializer.sv
// tb/tb_uxa_ps2_deserializer.sv - randomized self-checking bench against a bit-history model.
module tb_uxa_ps2_deserializer;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;

    logic       sys_clk_i = 1'b0;
    logic       reset_i   = 1'b0;
    logic       ps2_d_i   = 1'b1;
    logic       ps2_c_i   = 1'b1;
    logic [7:0] d_o;
    logic       frame_o;
`ifdef UXA_PS2_PARITY_CHECK_EN
    logic       parity_err_o;
`endif

    int checks = 0;
    int errors = 0;
    bit hist[$];

    uxa_ps2_deserializer #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .sys_clk_i   (sys_clk_i),
        .reset_i     (reset_i),
        .ps2_d_i     (ps2_d_i),
        .ps2_c_i     (ps2_c_i),
        .d_o         (d_o),
`ifdef UXA_PS2_PARITY_CHECK_EN
        .parity_err_o(parity_err_o),
`endif
        .frame_o     (frame_o)
    );

    always #40 sys_clk_i = ~sys_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Last 11 wire bits since reset, oldest at index 0; missing bits read as idle 1s.
    function automatic logic [10:0] model_window();
        logic [10:0] w;
        int n;
        w = '1;
        n = hist.size();
        for (int k = 0; k < 11; k++)
            if (n - 11 + k >= 0) w[k] = hist[n - 11 + k];
        return w;
    endfunction

    task automatic check_model(input string tag);
        logic [10:0] w;
        int ones;
        w = model_window();
        check_eq({tag, "_data"}, 32'(d_o), 32'(w[8:1]));
        check_eq({tag, "_frame"}, 32'(frame_o), 32'(w[0] == 1'b0 && w[10] == 1'b1));
`ifdef UXA_PS2_PARITY_CHECK_EN
        ones = 0;
        for (int k = 1; k <= 9; k++) ones += int'(w[k]);
        check_eq({tag, "_perr"}, 32'(parity_err_o),
                 32'(w[0] == 1'b0 && w[10] == 1'b1 && (ones % 2) == 0));
`else
        ones = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge sys_clk_i);
        reset_i = 1'b1;
        @(negedge sys_clk_i);
        reset_i = 1'b0;
        hist.delete();
    endtask

    task automatic glitch(input logic level, input int len);
        ps2_c_i = level;
        repeat (len) @(negedge sys_clk_i);
        ps2_c_i = ~level;
    endtask

    // Data changes at the start of the high phase; model checked late in the low phase.
    task automatic send_bit(input bit b, input int half, input bit glitch_lo, input bit glitch_hi);
        @(negedge sys_clk_i);
        ps2_d_i = b;
        if (glitch_hi) begin
            repeat (half / 2) @(negedge sys_clk_i);
            glitch(1'b0, FILTER_LEN - 1);
            repeat (half - half / 2 - (FILTER_LEN - 1)) @(negedge sys_clk_i);
        end else begin
            repeat (half) @(negedge sys_clk_i);
        end
        ps2_c_i = 1'b0;
        hist.push_back(b);
        if (glitch_lo) begin
            repeat (half / 2) @(negedge sys_clk_i);
            glitch(1'b1, FILTER_LEN - 1);
            repeat (half - half / 2 - (FILTER_LEN - 1)) @(negedge sys_clk_i);
        end else begin
            repeat (half) @(negedge sys_clk_i);
        end
        check_model("bit");
        ps2_c_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par, input bit stop, input int half,
                              input bit glitches);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++)
            send_bit(bits[i], half, glitches & ($urandom_range(0, 3) == 0),
                     glitches & ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        logic [7:0] rb;
        int half;
        int cut;

        do_reset();
        check_eq("reset_data", 32'(d_o), 32'h0FF);
        check_eq("reset_frame", 32'(frame_o), 32'h0);

        // 100 us PS/2 period at 80 ns sys_clk.
        send_frame(8'h64, 1'b1, 1'b1, 625, 1'b0);
        repeat (4) @(negedge sys_clk_i);
        check_eq("f64_data", 32'(d_o), 32'h64);
        check_eq("f64_frame", 32'(frame_o), 32'h1);
`ifdef UXA_PS2_PARITY_CHECK_EN
        check_eq("f64_perr_p1", 32'(parity_err_o), 32'h1);
`endif

        do_reset();
        check_eq("rst2_data", 32'(d_o), 32'h0FF);
        check_eq("rst2_frame", 32'(frame_o), 32'h0);

        for (int i = 0; i < 5; i++) send_bit(i[0], 40, 1'b0, 1'b0);
        do_reset();
        check_eq("partial_rst_frame", 32'(frame_o), 32'h0);
        send_frame(8'hA5, 1'b1, 1'b1, 40, 1'b0);
        check_eq("fA5_data", 32'(d_o), 32'hA5);
        check_eq("fA5_frame", 32'(frame_o), 32'h1);

        @(negedge sys_clk_i);
        glitch(1'b0, FILTER_LEN - 1);
        repeat (20) @(negedge sys_clk_i);
        check_eq("glitch_data", 32'(d_o), 32'hA5);
        check_eq("glitch_frame", 32'(frame_o), 32'h1);

        send_frame(8'h64, 1'b0, 1'b1, 40, 1'b0);
        check_eq("f64p0_data", 32'(d_o), 32'h64);
`ifdef UXA_PS2_PARITY_CHECK_EN
        check_eq("f64_perr_p0", 32'(parity_err_o), 32'h0);
`endif

        for (int it = 0; it < 25; it++) begin
            rb   = 8'($urandom);
            half = $urandom_range(30, 60);
            if ($urandom_range(0, 4) == 0) begin
                cut = $urandom_range(1, 10);
                for (int i = 0; i < cut; i++) send_bit(1'($urandom), half, 1'b0, 1'b0);
                repeat (10) @(negedge sys_clk_i);
                do_reset();
                check_model("rand_rst");
            end
            send_frame(rb, 1'($urandom), ($urandom_range(0, 5) != 0), half, 1'b1);
            repeat (10) @(negedge sys_clk_i);
            check_model("rand_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
